// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared duty type and PWM frame helpers for the LED driver
package led_pkg;

   localparam int LED_DUTY_W = 8;

   typedef logic [LED_DUTY_W-1:0] duty_t;

   // Last pwm_cnt value of a frame: the counter runs 0..2^w-2, so a frame is 2^w-1 ticks.
   function automatic int pwm_max(input int w);
      return (1 << w) - 2;
   endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and PWM frame counter, held at zero while disabled
module led_pwm_timebase
   import led_pkg::*;
#(
   parameter int DUTY_W   = LED_DUTY_W,
   parameter int PRESCALE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic              tick,
   output logic [DUTY_W-1:0] pwm_cnt,
   output logic              wrap
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(pwm_max(DUTY_W));

   logic [PS_W-1:0] prescaler;

   assign tick = enable && (prescaler == PS_LAST);
   assign wrap = tick && (pwm_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else if (!enable) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         if (tick) begin
            pwm_cnt <= wrap ? '0 : pwm_cnt + DUTY_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - per-channel PWM LED driver with frame-synchronous double-buffered duties
module led_pwm_driver
   import led_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int DUTY_W   = LED_DUTY_W,
   parameter int PRESCALE = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [NUM_CH*DUTY_W-1:0] duty_data,
   input  logic                     duty_valid,
   output logic                     duty_ready,
   output logic [NUM_CH-1:0]        led,
   output logic                     frame_start
);

   logic              tick;
   logic              wrap;
   logic [DUTY_W-1:0] pwm_cnt;
   logic [DUTY_W-1:0] active  [NUM_CH];
   logic [DUTY_W-1:0] pending [NUM_CH];
   logic              pend_flag;
   logic              boundary;

   led_pwm_timebase #(
      .DUTY_W   (DUTY_W),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wrap    (wrap)
   );

   // A disabled driver has no frame in flight, so any edge is a safe commit point.
   assign boundary   = !enable || (tick && wrap);
   assign duty_ready = !pend_flag;

   // Commit and accept are exclusive: commit needs the flag set, accept needs it clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            active[i]  <= '0;
            pending[i] <= '0;
         end
         pend_flag <= 1'b0;
      end else if (pend_flag && boundary) begin
         active    <= pending;
         pend_flag <= 1'b0;
      end else if (duty_valid && !pend_flag) begin
         for (int i = 0; i < NUM_CH; i++) begin
            pending[i] <= duty_data[i*DUTY_W +: DUTY_W];
         end
         pend_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led         <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= wrap;
         for (int i = 0; i < NUM_CH; i++) begin
            led[i] <= enable && (pwm_cnt < active[i]);
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - randomized self-checking bench for led_pwm_driver against a frame-arithmetic model
module tb_led_pwm_driver;
   import led_pkg::*;

   localparam int NCH   = 8;
   localparam int PS    = 4;
   localparam int FRAME = PS * 255;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            enable = 1'b0;
   logic [NCH*8-1:0] duty_data = '0;
   logic            duty_valid = 1'b0;
   logic            duty_ready;
   logic [NCH-1:0]  led;
   logic            frame_start;

   int total = 0;
   int bad   = 0;

   led_pwm_driver #(.NUM_CH(NCH), .DUTY_W(8), .PRESCALE(PS)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .duty_data   (duty_data),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .led         (led),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Reference: position in the frame is the number of enabled clocks since the frame began.
   int             m_ck;
   duty_t          m_active [NCH];
   duty_t          m_pend   [NCH];
   logic           m_flag;
   logic [NCH-1:0] exp_led;
   logic           exp_fs;
   logic           exp_ready;

   assign exp_ready = !m_flag;

   function automatic int slot_of(input int ck);
      return (ck / PS) % 255;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ck    <= 0;
         m_flag  <= 1'b0;
         exp_led <= '0;
         exp_fs  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            m_active[i] <= '0;
            m_pend[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            exp_led[i] <= enable && (slot_of(m_ck) < int'(m_active[i]));
         end
         exp_fs <= enable && (m_ck == FRAME - 1);
         if (m_flag && (!enable || m_ck == FRAME - 1)) begin
            m_active <= m_pend;
            m_flag   <= 1'b0;
         end else if (duty_valid && !m_flag) begin
            for (int i = 0; i < NCH; i++) m_pend[i] <= duty_data[i*8 +: 8];
            m_flag <= 1'b1;
         end
         m_ck <= enable ? (m_ck + 1) % FRAME : 0;
      end
   end

   task automatic test_reset();
      int n;
      rst = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_data = '0;
      repeat (3) @(negedge clk);
      total++;
      if (led !== 8'h00 || duty_ready !== 1'b1 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL reset_state led=%h rdy=%b fs=%b want led=00 rdy=1 fs=0", led, duty_ready, frame_start);
      end
      rst = 1'b1; enable = 1'b1;
      n = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clk); n++;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL reset_run led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (frame_start === 1'b1) break;
      end
      total++;
      if (n != FRAME) begin
         bad++;
         $display("FAIL reset_first_frame got=%0d want=%0d", n, FRAME);
      end
   endtask

   task automatic test_handshake();
      int  hi [NCH];
      bit  lit_early;
      bit  found;
      repeat (300) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL hs_pre led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
      end
      duty_data = {NCH{8'h80}}; duty_valid = 1'b1;
      @(negedge clk);
      duty_valid = 1'b0;
      total++;
      if (duty_ready !== 1'b0) begin
         bad++;
         $display("FAIL hs_ready_drop got=%b want=0", duty_ready);
      end
      lit_early = 1'b0; found = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL hs_wait led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (led !== 8'h00) lit_early = 1'b1;
         if (frame_start === 1'b1) begin found = 1'b1; break; end
      end
      total++;
      if (!found || lit_early || duty_ready !== 1'b1) begin
         bad++;
         $display("FAIL hs_commit found=%b lit_early=%b rdy=%b want 1 0 1", found, lit_early, duty_ready);
      end
      for (int i = 0; i < NCH; i++) hi[i] = 0;
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL hs_frame led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         for (int i = 0; i < NCH; i++) hi[i] += int'(led[i]);
      end
      for (int i = 0; i < NCH; i++) begin
         total++;
         if (hi[i] != 128 * PS) begin
            bad++;
            $display("FAIL hs_high_time ch=%0d got=%0d want=%0d", i, hi[i], 128 * PS);
         end
      end
   endtask

   task automatic test_extremes();
      int hi [NCH];
      logic [NCH*8-1:0] w;
      w = {$urandom, $urandom};
      w[7:0] = 8'h00; w[15:8] = 8'hFF; w[23:16] = 8'h01; w[63:56] = 8'hFE;
      duty_data = w; duty_valid = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         duty_valid = 1'b0;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL ext_wait led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (frame_start === 1'b1) break;
      end
      for (int i = 0; i < NCH; i++) hi[i] = 0;
      for (int f = 0; f < 2; f++) begin
         for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            total++;
            if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
               bad++;
               $display("FAIL ext_frame led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
            end
            for (int i = 0; i < NCH; i++) hi[i] += int'(led[i]);
         end
      end
      total++;
      if (hi[0] != 0 || hi[1] != 2 * FRAME || hi[2] != 2 * PS || hi[7] != 2 * (FRAME - PS)) begin
         bad++;
         $display("FAIL ext_high_time got=%0d,%0d,%0d,%0d want=0,%0d,%0d,%0d",
                  hi[0], hi[1], hi[2], hi[7], 2 * FRAME, 2 * PS, 2 * (FRAME - PS));
      end
   endtask

   task automatic test_back_to_back();
      bit found;
      duty_data = {$urandom, $urandom}; duty_valid = 1'b1;
      @(negedge clk);
      duty_data = {$urandom, $urandom};
      found = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL b2b_hold led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (duty_ready === 1'b1) begin found = 1'b1; break; end
      end
      total++;
      if (!found || frame_start !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready_at_wrap found=%b fs=%b want 1 1", found, frame_start);
      end
      @(negedge clk);
      duty_valid = 1'b0;
      total++;
      if (duty_ready !== 1'b0 || led !== exp_led) begin
         bad++;
         $display("FAIL b2b_accept rdy=%b want=0 led=%h/%h", duty_ready, led, exp_led);
      end
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL b2b_run led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (frame_start === 1'b1) break;
      end
   endtask

   task automatic test_coincident();
      int k;
      k = 0;
      while (m_ck != FRAME - 1 && k < 2 * FRAME) begin
         @(negedge clk); k++;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL co_seek led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
      end
      duty_data = {$urandom, $urandom}; duty_valid = 1'b1;
      @(negedge clk);
      duty_valid = 1'b0;
      total++;
      if (frame_start !== 1'b1 || duty_ready !== 1'b0) begin
         bad++;
         $display("FAIL co_load fs=%b rdy=%b want 1 0", frame_start, duty_ready);
      end
      repeat (FRAME) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL co_frame led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
      end
      total++;
      if (frame_start !== 1'b1 || duty_ready !== 1'b1) begin
         bad++;
         $display("FAIL co_commit fs=%b rdy=%b want 1 1", frame_start, duty_ready);
      end
   endtask

   task automatic test_disable();
      int n;
      duty_data = {$urandom, $urandom} | 64'h0101010101010101; duty_valid = 1'b1;
      repeat (60) begin
         @(negedge clk);
         duty_valid = 1'b0;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL dis_pre led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
      end
      enable = 1'b0;
      @(negedge clk);
      total++;
      if (led !== 8'h00 || duty_ready !== 1'b1 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL dis_dark led=%h rdy=%b fs=%b want 00 1 0", led, duty_ready, frame_start);
      end
      repeat (5) @(negedge clk);
      enable = 1'b1;
      n = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk); n++;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL dis_resume led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (frame_start === 1'b1) break;
      end
      total++;
      if (n != FRAME) begin
         bad++;
         $display("FAIL dis_first_frame got=%0d want=%0d", n, FRAME);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         repeat ($urandom_range(0, 1200)) begin
            @(negedge clk);
            total++;
            if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
               bad++;
               $display("FAIL rnd_run led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
            end
         end
         duty_data  = {$urandom, $urandom};
         duty_valid = 1'b1;
         if ($urandom_range(0, 3) == 0) enable = 1'b0;
         repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            duty_valid = 1'b0;
            total++;
            if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
               bad++;
               $display("FAIL rnd_edge led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
            end
         end
         enable = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2 * FRAME && duty_ready !== 1'b1; k++) @(negedge clk);
      duty_data = {NCH{8'hFF}}; duty_valid = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         duty_valid = 1'b0;
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL ar_wait led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
         if (frame_start === 1'b1 && duty_ready === 1'b1) break;
      end
      repeat (100) @(negedge clk);
      total++;
      if (led !== 8'hFF) begin
         bad++;
         $display("FAIL ar_lit got=%h want=ff", led);
      end
      duty_data = {$urandom, $urandom}; duty_valid = 1'b1;
      @(negedge clk);
      duty_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if (led !== 8'h00 || duty_ready !== 1'b1 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL ar_async_clear led=%h rdy=%b fs=%b want 00 1 0", led, duty_ready, frame_start);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
         @(negedge clk);
         total++;
         if (led !== exp_led || frame_start !== exp_fs || duty_ready !== exp_ready) begin
            bad++;
            $display("FAIL ar_after led=%h/%h fs=%b/%b rdy=%b/%b", led, exp_led, frame_start, exp_fs, duty_ready, exp_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_extremes();
      test_back_to_back();
      test_coincident();
      test_disable();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
